// File: rtl/regfile_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | regfile_pkg : shared register-file constants and address type    |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
package regfile_pkg;
  localparam int REG_WIDTH = 32;
  localparam int REG_DEPTH = 32;
  localparam int REG_AW    = $clog2(REG_DEPTH);

  typedef logic [REG_AW-1:0] regaddr_t;

  localparam regaddr_t ZERO_ADDR = '0;
endpackage
`default_nettype wire

// File: rtl/regfile_scb_board.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | regfile_scb_board : per-register busy bits and pending counter   |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module regfile_scb_board
  import regfile_pkg::*;
#(
  parameter int DEPTH = REG_DEPTH,
  parameter int AW    = $clog2(REG_DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             wr0_commit,
  input  logic [AW-1:0]    wraddr0,
  input  logic             wr1_commit,
  input  logic [AW-1:0]    wraddr1,
  input  logic             resv_commit,
  input  logic [AW-1:0]    resv_addr,
  output logic [DEPTH-1:0] busy,
  output logic [AW:0]      pending_cnt
);
  logic [DEPTH-1:0] r_busy;
  logic [AW:0]      r_cnt;
  logic [DEPTH-1:0] w_set;
  logic [DEPTH-1:0] w_clr;
  logic [DEPTH-1:0] w_busy_nxt;
  logic [AW:0]      w_cnt_nxt;

  // Reservation beats a same-cycle write: the reserving instruction is the newer producer.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_set[i] = resv_commit && (resv_addr == AW'(i));
      w_clr[i] = (wr0_commit && (wraddr0 == AW'(i))) || (wr1_commit && (wraddr1 == AW'(i)));
    end
    w_busy_nxt = w_set | (r_busy & ~w_clr);
  end

  // Only real 0->1 and 1->0 transitions move the count.
  always_comb begin
    w_cnt_nxt = r_cnt;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_set[i] && !r_busy[i])
        w_cnt_nxt = w_cnt_nxt + (AW+1)'(1);
      if (r_busy[i] && w_clr[i] && !w_set[i])
        w_cnt_nxt = w_cnt_nxt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_busy <= '0;
      r_cnt  <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign busy        = r_busy;
  assign pending_cnt = r_cnt;
endmodule
`default_nettype wire

// File: rtl/regfile_scb.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | regfile_scb : 2R/2W register file with bypass and busy tracking  |
// | Rev 1.0                                                          |
// +-----------------------------------------------------------------+
module regfile_scb
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REG_WIDTH,
  parameter int DEPTH    = REG_DEPTH,
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [AW-1:0]    rdaddr1,
  input  logic [AW-1:0]    rdaddr2,
  output logic [WIDTH-1:0] rddata1,
  output logic [WIDTH-1:0] rddata2,
  output logic             rdbusy1,
  output logic             rdbusy2,
  input  logic             RegWrite0,
  input  logic [AW-1:0]    wraddr0,
  input  logic [WIDTH-1:0] wrdata0,
  input  logic             RegWrite1,
  input  logic [AW-1:0]    wraddr1,
  input  logic [WIDTH-1:0] wrdata1,
  input  logic             resv_valid,
  input  logic [AW-1:0]    resv_addr,
  output logic [AW:0]      pending_cnt
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] w_busy;
  logic             w_commit0;
  logic             w_commit1;
  logic             w_resv_ok;
  logic [AW-1:0]    w_rdaddr [2];
  logic [WIDTH-1:0] w_rddata [2];
  logic             w_rdbusy [2];

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (int'(a) < DEPTH) && !(ZERO_REG && (a == '0));
  endfunction

  assign w_commit0 = RegWrite0 && addr_ok(wraddr0);
  assign w_commit1 = RegWrite1 && addr_ok(wraddr1);
  assign w_resv_ok = resv_valid && addr_ok(resv_addr);

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
      always_ff @(posedge clock) begin
        if (!reset_n)
          r_mem[i] <= '0;
        else if (w_commit1 && (wraddr1 == AW'(i)))
          r_mem[i] <= wrdata1;
        else if (w_commit0 && (wraddr0 == AW'(i)))
          r_mem[i] <= wrdata0;
      end
    end
  endgenerate

  regfile_scb_board #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_board (
    .clock       (clock),
    .reset_n     (reset_n),
    .wr0_commit  (w_commit0),
    .wraddr0     (wraddr0),
    .wr1_commit  (w_commit1),
    .wraddr1     (wraddr1),
    .resv_commit (w_resv_ok),
    .resv_addr   (resv_addr),
    .busy        (w_busy),
    .pending_cnt (pending_cnt)
  );

  assign w_rdaddr[0] = rdaddr1;
  assign w_rdaddr[1] = rdaddr2;

  generate
    for (genvar k = 0; k < 2; k++) begin : g_rd
      logic [WIDTH-1:0] w_stored;
      logic             w_bstored;
      logic             w_hit0;
      logic             w_hit1;
      logic [WIDTH-1:0] w_data;
      logic             w_bsy;

      always_comb begin
        w_stored  = '0;
        w_bstored = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          if (w_rdaddr[k] == AW'(i)) begin
            w_stored  = r_mem[i];
            w_bstored = w_busy[i];
          end
        end
        w_hit0 = BYPASS && w_commit0 && (wraddr0 == w_rdaddr[k]);
        w_hit1 = BYPASS && w_commit1 && (wraddr1 == w_rdaddr[k]);
        w_data = '0;
        w_bsy  = 1'b0;
        if (addr_ok(w_rdaddr[k])) begin
          if (w_hit1)
            w_data = wrdata1;
          else if (w_hit0)
            w_data = wrdata0;
          else
            w_data = w_stored;
          w_bsy = w_bstored && !(w_hit0 || w_hit1);
        end
      end

      assign w_rddata[k] = w_data;
      assign w_rdbusy[k] = w_bsy;
    end
  endgenerate

  assign rddata1 = w_rddata[0];
  assign rddata2 = w_rddata[1];
  assign rdbusy1 = w_rdbusy[0];
  assign rdbusy2 = w_rdbusy[1];
endmodule
`default_nettype wire

// File: doc/regfile_scb.md
# regfile_scb

Parametrised multi-write-port register file with an integrated busy scoreboard, the successor to the fixed 32×32 single-write register file in the MIPS datapath. It gives the pipelined core two combinational read ports with optional write-to-read bypass, and two write-back ports (ALU and load) with fixed priority. A per-register pending bit lets decode stall on RAW hazards. Register 0 is optionally hard-wired to zero, per MIPS.

## Interface
- WIDTH, 32, data width in bits
- DEPTH, 32, number of registers (≥2, need not be a power of 2)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports
- ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes/reservations
- AW (localparam), $clog2(DEPTH), address width
---
- clock  in  1  rising-edge clock; only clock
- reset_n  in  1  synchronous, active-low reset
- rdaddr1, rdaddr2  in  AW  read addresses
- rddata1, rddata2  out  WIDTH  read data, combinational
- rdbusy1, rdbusy2  out  1  addressed register has an outstanding producer
- RegWrite0 / wraddr0 / wrdata0  in  1/AW/WIDTH  write port 0 (ALU write-back)
- RegWrite1 / wraddr1 / wrdata1  in  1/AW/WIDTH  write port 1 (load write-back), higher priority
- resv_valid / resv_addr  in  1/AW  issue-stage reservation: mark register pending
- pending_cnt  out  AW+1  number of registers currently pending

## Operation
- Storage: DEPTH×WIDTH array; busy[DEPTH] bit vector; pending_cnt register.
- Write (clock edge, reset_n=1): port p commits when RegWrite_p=1, address < DEPTH, and not (ZERO_REG && address==0). If both ports commit to the same address, port 1 data is stored.
- Read: address ≥ DEPTH → 0. ZERO_REG && address 0 → 0. BYPASS=1 and a committing write hits the address this cycle → that write's data (port 1 over port 0). Otherwise stored value.
- Scoreboard, per register at each edge:
  - set busy on a valid reservation (same address filters as writes);
  - clear busy on any committing write to it;
  - same-cycle reservation and write to one address: busy ends 1 (reservation wins, new producer).
- rdbusy_k = busy[addr_k] & ~(BYPASS && committing write hits addr_k this cycle). Out-of-range or zero-reg address → 0.
- pending_cnt tracks popcount(busy) incrementally; the net delta per cycle is in {-2..+1}. It never under- or overflows: a set on an already-busy bit and a clear on an idle bit do not count.
- Reset (reset_n=0 at an edge): all registers 0, busy all 0, pending_cnt 0. Writes and reservations presented in that cycle are discarded. Reset asserted mid-stream simply wins.

## Timing
- Reads and rdbusy: zero-latency combinational from addresses and same-cycle write ports.
- A write is visible on reads the same cycle with BYPASS=1, otherwise from the next cycle.
- Reservation is visible on rdbusy the cycle after resv_valid.
- pending_cnt is registered and updates on the edge following the causing event.
- After reset deassertion, all outputs are 0 (rddata=0, rdbusy=0, pending_cnt=0) until the first write or reservation edge.

## Structure
- Shared package regfile_pkg: default WIDTH/DEPTH constants, `regaddr_t` typedef, ZERO_ADDR constant, reused by decode and hazard units.
- One sub-module is natural: regfile_scb_board (busy vector + pending_cnt), instantiated once. Data array and read muxes stay in the top.

## Test plan
- Reset: preload r5=0xDEADBEEF, pull reset_n low one edge → rddata(5)=0, pending_cnt=0, no busy bits.
- Write port conflict: RegWrite0 r7=0x11, RegWrite1 r7=0x22 in the same cycle → next cycle r7 reads 0x22. With BYPASS=1 the same cycle also reads 0x22.
- Zero register: write 0xFFFF_FFFF and reserve r0 → reads 0, rdbusy 0, pending_cnt unchanged.
- Scoreboard: reserve r3 → rdbusy1(r3)=1 and pending_cnt=1 next cycle. Write r3=0x42 → rdbusy=0 in the same cycle (BYPASS), pending_cnt=0 the cycle after.
- Simultaneous events: reserve r4 while port 0 writes r4 → r4 busy=1, pending_cnt=1. Two writes clearing two busy regs in one cycle → pending_cnt drops by 2.
- DEPTH=24, BYPASS=0: write to address 30 is ignored and reads 0. A write to r9 is not visible until the next cycle.
